// File: rtl/rfblackwidow_ichit_plru.sv
// N-way instruction-cache hit detector for the BlackWidow fetch stage.
// Owns per-line valid bits and tree-PLRU state; registered hit/victim/error outputs.
module rfblackwidow_ichit_plru #(
   parameter int WAYS  = 4,
   parameter int LINES = 128,
   parameter int LOBIT = 6,
   parameter int AWID  = 32,
   localparam int LBITS = $clog2(LINES),
   localparam int TW    = AWID - LOBIT,
   localparam int WB    = $clog2(WAYS)
) (
   input  logic              rst,
   input  logic              clk,
   input  logic [AWID-1:0]   ip,
   input  logic [WAYS*TW-1:0] tag,
   input  logic              fill_v,
   input  logic [WB-1:0]     fill_way,
   input  logic [AWID-1:0]   fill_adr,
   input  logic              inv_line,
   input  logic [AWID-1:0]   inv_adr,
   input  logic              inv_all,
   output logic              busy,
   output logic              ihit,
   output logic [WB-1:0]     rway,
   output logic [TW-1:0]     vtag,
   output logic              icv,
   output logic [WB-1:0]     victim_way,
   output logic              multihit
);

   localparam int NB = WAYS - 1;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [LBITS-1:0] cnt_q, cnt_d;
   logic             busy_s;

   logic [WAYS-1:0]  valid_q [LINES];
   logic [WAYS-1:0]  valid_d [LINES];
   logic [NB-1:0]    plru_q  [LINES];
   logic [NB-1:0]    plru_d  [LINES];

   logic [LBITS-1:0] idx_s, fidx_s, iidx_s;
   logic [WAYS-1:0]  line_valid_s, match_s;
   logic             hit_raw_s;
   logic [WB-1:0]    hit_way_s, inv_way_s, victim_s;
   logic [TW-1:0]    hit_tag_s;
   logic [WB:0]      nmatch_s;

   logic             hit_raw_q;
   logic             ihit_q, ihit_d;
   logic [WB-1:0]    rway_q, rway_d;
   logic [TW-1:0]    vtag_q, vtag_d;
   logic             icv_q, icv_d;
   logic [WB-1:0]    victim_q, victim_d;
   logic             multihit_q, multihit_d;

   // Heap-ordered tree: node n has children 2n+1 (lower) and 2n+2 (upper); bit=1 means upper.
   function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits, input logic [WB-1:0] way);
      logic [NB-1:0] r;
      int            node;
      r    = bits;
      node = 0;
      for (int l = 0; l < WB; l++) begin
         r[node] = ~way[WB-1-l];
         node    = 2*node + 1 + int'(way[WB-1-l]);
      end
      return r;
   endfunction

   function automatic logic [WB-1:0] plru_walk(input logic [NB-1:0] bits);
      logic [WB-1:0] w;
      int            node;
      w    = '0;
      node = 0;
      for (int l = 0; l < WB; l++) begin
         w[WB-1-l] = bits[node];
         node      = 2*node + 1 + int'(bits[node]);
      end
      return w;
   endfunction

   // Invalidate-all state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Invalidate-all next state; a new inv_all during a sweep is ignored
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (inv_all) begin
               state_d = SWEEP;
            end else begin
               state_d = IDLE;
            end
         end
         SWEEP: begin
            cnt_d = cnt_q + LBITS'(1);
            if (cnt_q == LBITS'(LINES-1)) begin
               state_d = IDLE;
            end else begin
               state_d = SWEEP;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Invalidate-all outputs
   always_comb begin
      busy_s = (state_q == SWEEP);
   end

   // Tag compare, hit way, match count and victim selection for the indexed line
   always_comb begin
      idx_s        = ip[LOBIT +: LBITS];
      line_valid_s = valid_q[idx_s];
      match_s      = '0;
      hit_way_s    = '0;
      hit_tag_s    = '0;
      nmatch_s     = '0;
      inv_way_s    = '0;
      for (int w = 0; w < WAYS; w++) begin
         match_s[w] = (tag[w*TW +: TW] == ip[AWID-1:LOBIT]) && line_valid_s[w] && !busy_s;
         hit_way_s  = match_s[w] ? WB'(w) : hit_way_s;
         hit_tag_s  = match_s[w] ? tag[w*TW +: TW] : hit_tag_s;
         nmatch_s   = nmatch_s + (WB+1)'(match_s[w]);
      end
      for (int w = WAYS-1; w >= 0; w--) begin
         inv_way_s = line_valid_s[w] ? inv_way_s : WB'(w);
      end
      hit_raw_s = |match_s;
      victim_s  = (&line_valid_s) ? plru_walk(plru_q[idx_s]) : inv_way_s;
   end

   // Valid/PLRU updates: sweep clears, fill beats hit on PLRU, invalidate beats fill on valid
   always_comb begin
      valid_d = valid_q;
      plru_d  = plru_q;
      fidx_s  = fill_adr[LOBIT +: LBITS];
      iidx_s  = inv_adr[LOBIT +: LBITS];
      if (busy_s) begin
         valid_d[cnt_q] = '0;
         plru_d[cnt_q]  = '0;
      end else begin
         if (hit_raw_s && !(fill_v && (fidx_s == idx_s))) begin
            plru_d[idx_s] = plru_touch(plru_q[idx_s], hit_way_s);
         end else begin
            plru_d[idx_s] = plru_d[idx_s];
         end
         if (fill_v) begin
            valid_d[fidx_s][fill_way] = 1'b1;
            plru_d[fidx_s]            = plru_touch(plru_q[fidx_s], fill_way);
         end else begin
            valid_d[fidx_s] = valid_d[fidx_s];
         end
         if (inv_line) begin
            valid_d[iidx_s] = '0;
         end else begin
            valid_d[iidx_s] = valid_d[iidx_s];
         end
      end
   end

   // Valid and PLRU arrays
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++) begin
            valid_q[i] <= '0;
            plru_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         plru_q  <= plru_d;
      end
   end

   // Output register next values; rway/vtag hold on a miss
   always_comb begin
      ihit_d     = hit_raw_s & hit_raw_q;
      rway_d     = hit_raw_s ? hit_way_s : rway_q;
      vtag_d     = hit_raw_s ? hit_tag_s : vtag_q;
      icv_d      = |line_valid_s;
      victim_d   = victim_s;
      multihit_d = (nmatch_s > (WB+1)'(1));
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_raw_q  <= 1'b0;
         ihit_q     <= 1'b0;
         rway_q     <= '0;
         vtag_q     <= '0;
         icv_q      <= 1'b0;
         victim_q   <= '0;
         multihit_q <= 1'b0;
      end else begin
         hit_raw_q  <= hit_raw_s;
         ihit_q     <= ihit_d;
         rway_q     <= rway_d;
         vtag_q     <= vtag_d;
         icv_q      <= icv_d;
         victim_q   <= victim_d;
         multihit_q <= multihit_d;
      end
   end

   assign busy       = busy_s;
   assign ihit       = ihit_q;
   assign rway       = rway_q;
   assign vtag       = vtag_q;
   assign icv        = icv_q;
   assign victim_way = victim_q;
   assign multihit   = multihit_q;

endmodule

// File: tb/tb_rfblackwidow_ichit_plru.sv
// Directed bench for rfblackwidow_ichit_plru (4 ways, 128 lines, 64-byte lines).
// Expected values are hand-derived from the tree-PLRU and hit-qualification rules.
module tb_rfblackwidow_ichit_plru;

   localparam int WAYS = 4;
   localparam int TW   = 26;
   localparam int WB   = 2;

   logic              rst;
   logic              clk;
   logic [31:0]       ip;
   logic [WAYS*TW-1:0] tag;
   logic              fill_v;
   logic [WB-1:0]     fill_way;
   logic [31:0]       fill_adr;
   logic              inv_line;
   logic [31:0]       inv_adr;
   logic              inv_all;
   logic              busy;
   logic              ihit;
   logic [WB-1:0]     rway;
   logic [TW-1:0]     vtag;
   logic              icv;
   logic [WB-1:0]     victim_way;
   logic              multihit;

   int checks;
   int failures;

   rfblackwidow_ichit_plru dut (
      .rst        (rst),
      .clk        (clk),
      .ip         (ip),
      .tag        (tag),
      .fill_v     (fill_v),
      .fill_way   (fill_way),
      .fill_adr   (fill_adr),
      .inv_line   (inv_line),
      .inv_adr    (inv_adr),
      .inv_all    (inv_all),
      .busy       (busy),
      .ihit       (ihit),
      .rway       (rway),
      .vtag       (vtag),
      .icv        (icv),
      .victim_way (victim_way),
      .multihit   (multihit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tags(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                           input logic [TW-1:0] t2, input logic [TW-1:0] t3);
      tag = {t3, t2, t1, t0};
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      ip       = 32'h0000_1000;
      set_tags(26'h40, 26'h40, 26'h40, 26'h40);
      fill_v   = 1'b0;
      fill_way = 2'd0;
      fill_adr = 32'h0;
      inv_line = 1'b0;
      inv_adr  = 32'h0;
      inv_all  = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_icv", 32'(icv), 32'd0);
      check("rst_ihit", 32'(ihit), 32'd0);
      check("rst_victim", 32'(victim_way), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rway", 32'(rway), 32'd0);
      check("rst_vtag", 32'(vtag), 32'd0);
      check("rst_multihit", 32'(multihit), 32'd0);

      // fill way 2 of line 0x40, then look it up
      fill_v   = 1'b1;
      fill_way = 2'd2;
      fill_adr = 32'h0000_1000;
      step();
      fill_v = 1'b0;
      step();
      check("fill_rway", 32'(rway), 32'd2);
      check("fill_vtag", 32'(vtag), 32'h40);
      check("fill_icv", 32'(icv), 32'd1);
      check("fill_ihit_first", 32'(ihit), 32'd0);
      check("fill_victim_invalid", 32'(victim_way), 32'd0);
      step();
      check("fill_ihit_second", 32'(ihit), 32'd1);

      // fill remaining ways with non-matching tags, then hit way 0 and way 2
      set_tags(26'h100, 26'h101, 26'h102, 26'h103);
      fill_v   = 1'b1;
      fill_way = 2'd0;
      step();
      fill_way = 2'd1;
      step();
      fill_way = 2'd3;
      step();
      fill_v = 1'b0;
      set_tags(26'h40, 26'h101, 26'h102, 26'h103);
      step();
      check("hit0_rway", 32'(rway), 32'd0);
      step();
      check("hit0_ihit", 32'(ihit), 32'd1);
      set_tags(26'h100, 26'h101, 26'h40, 26'h103);
      step();
      check("hit2_rway", 32'(rway), 32'd2);
      step();
      check("plru_victim", 32'(victim_way), 32'd1);
      check("plru_icv", 32'(icv), 32'd1);
      check("plru_ihit", 32'(ihit), 32'd1);

      // invalidate the line
      inv_line = 1'b1;
      inv_adr  = 32'h0000_1000;
      step();
      inv_line = 1'b0;
      step();
      check("inv_victim", 32'(victim_way), 32'd0);
      check("inv_icv", 32'(icv), 32'd0);
      check("inv_ihit", 32'(ihit), 32'd0);
      check("inv_rway_hold", 32'(rway), 32'd2);
      step();
      check("inv_ihit_later", 32'(ihit), 32'd0);

      // same tag in ways 1 and 3
      set_tags(26'h100, 26'h40, 26'h102, 26'h40);
      fill_v   = 1'b1;
      fill_way = 2'd1;
      step();
      fill_way = 2'd3;
      step();
      fill_v = 1'b0;
      step();
      check("mh_multihit", 32'(multihit), 32'd1);
      check("mh_rway", 32'(rway), 32'd3);
      check("mh_vtag", 32'(vtag), 32'h40);
      fill_v   = 1'b1;
      fill_way = 2'd0;
      fill_adr = 32'h0000_1FC0;
      step();
      fill_v = 1'b0;
      step();

      // invalidate-all sweep, with a second inv_all ignored mid-sweep
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      for (int i = 0; i < 128; i++) begin
         check("sweep_busy", 32'(busy), 32'd1);
         if (i >= 1) begin
            check("sweep_ihit", 32'(ihit), 32'd0);
         end
         if (i == 50) begin
            inv_all = 1'b1;
         end
         if (i == 51) begin
            inv_all = 1'b0;
         end
         step();
      end
      check("sweep_done_busy", 32'(busy), 32'd0);
      check("sweep_done_icv", 32'(icv), 32'd0);
      check("sweep_done_ihit", 32'(ihit), 32'd0);
      check("sweep_done_multihit", 32'(multihit), 32'd0);
      ip = 32'h0000_1FC0;
      set_tags(26'h7F, 26'h101, 26'h102, 26'h103);
      step();
      step();
      check("sweep_line127_icv", 32'(icv), 32'd0);
      check("sweep_line127_ihit", 32'(ihit), 32'd0);

      // fill and invalidate of the same line in the same cycle
      ip = 32'h0000_1000;
      set_tags(26'h40, 26'h101, 26'h102, 26'h103);
      fill_v   = 1'b1;
      fill_way = 2'd0;
      fill_adr = 32'h0000_1000;
      inv_line = 1'b1;
      inv_adr  = 32'h0000_1000;
      step();
      fill_v   = 1'b0;
      inv_line = 1'b0;
      step();
      check("fillinv_icv", 32'(icv), 32'd0);
      step();
      check("fillinv_ihit", 32'(ihit), 32'd0);

      // reset in the middle of a sweep
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      step();
      step();
      step();
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_busy_after", 32'(busy), 32'd0);
      check("midrst_ihit", 32'(ihit), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("midrst_busy_released", 32'(busy), 32'd0);
      check("midrst_icv", 32'(icv), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
